// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single shared SRAM port.
// Master 0 is the CPU core, master 1 is the debug/loader port. Arbitration is
// combinational with a round-robin tie-break; read responses are steered back
// to their issuer through a fixed-depth tag pipeline matching RD_LAT.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   // master 0 (CPU core)
   input  logic                m0_req_i,
   input  logic                m0_we_i,
   input  logic [ADDR_W-1:0]   m0_addr_i,
   input  logic [DATA_W-1:0]   m0_wdata_i,
   input  logic [DATA_W/8-1:0] m0_be_i,
   output logic                m0_gnt_o,
   output logic                m0_rvalid_o,
   output logic [DATA_W-1:0]   m0_rdata_o,
   // master 1 (debug/loader)
   input  logic                m1_req_i,
   input  logic                m1_we_i,
   input  logic [ADDR_W-1:0]   m1_addr_i,
   input  logic [DATA_W-1:0]   m1_wdata_i,
   input  logic [DATA_W/8-1:0] m1_be_i,
   output logic                m1_gnt_o,
   output logic                m1_rvalid_o,
   output logic [DATA_W-1:0]   m1_rdata_o,
   // shared memory port
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i
);

   localparam int BE_W = DATA_W / 8;

   logic              last_grant;   // id of the master granted most recently
   logic              win;          // id of the current winner
   logic              any_req;
   logic              sel_we;
   logic [BE_W-1:0]   sel_be;
   logic [DATA_W-1:0] sel_wdata;
   logic              accept;
   logic              rd_accept;
   logic [RD_LAT-1:0] tag_vld;      // index 0 = newest, RD_LAT-1 = tail
   logic [RD_LAT-1:0] tag_id;
   logic              tail_vld;
   logic              tail_id;

   // Pick the winner: a lone requester wins, a tie goes to the master not granted last
   always_comb begin
      win = m1_req_i;
      if (m0_req_i && m1_req_i) begin
         win = ~last_grant;
      end
   end

   // Request mux; reset forces the memory side idle
   always_comb begin
      any_req     = m0_req_i | m1_req_i;
      sel_we      = win ? m1_we_i    : m0_we_i;
      sel_be      = win ? m1_be_i    : m0_be_i;
      sel_wdata   = win ? m1_wdata_i : m0_wdata_i;
      mem_req_o   = rst_n_i & any_req;
      mem_we_o    = mem_req_o & sel_we;
      mem_addr_o  = win ? m1_addr_i : m0_addr_i;
      mem_wdata_o = mem_we_o ? sel_wdata : '0;
      mem_be_o    = mem_we_o ? sel_be    : '0;
      accept      = mem_req_o & mem_gnt_i;
      rd_accept   = accept & ~sel_we;
      m0_gnt_o    = accept & ~win;
      m1_gnt_o    = accept & win;
   end

   // Round-robin pointer moves only on an accepted transfer; reset favours master 0
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         last_grant <= 1'b1;
      end else if (accept) begin
         last_grant <= win;
      end
   end

   // Read-ownership pipeline: one entry per cycle of memory read latency
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else begin
         tag_vld[0] <= rd_accept;
         tag_id[0]  <= win;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_id[i]  <= tag_id[i-1];
         end
      end
   end

   // Response steering: only a valid tail entry qualifies mem_rvalid_i
   always_comb begin
      tail_vld    = tag_vld[RD_LAT-1];
      tail_id     = tag_id[RD_LAT-1];
      m0_rvalid_o = rst_n_i & mem_rvalid_i & tail_vld & ~tail_id;
      m1_rvalid_o = rst_n_i & mem_rvalid_i & tail_vld & tail_id;
      m0_rdata_o  = mem_rdata_i;
      m1_rdata_o  = mem_rdata_i;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with RD_LAT=3. The bench plays the SRAM: it records
// each accepted read as an expected response {due cycle, owner, data} in a
// queue, drives mem_rvalid_i/mem_rdata_i when an entry falls due, and checks
// grants, the muxed request and the returned responses every cycle.
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LAT = 3;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          m0_req_i, m0_we_i, m1_req_i, m1_we_i;
   logic [AW-1:0] m0_addr_i, m1_addr_i;
   logic [DW-1:0] m0_wdata_i, m1_wdata_i;
   logic [3:0]    m0_be_i, m1_be_i;
   logic          m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
   logic [DW-1:0] m0_rdata_o, m1_rdata_o;
   logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o, mem_rdata_i;
   logic [3:0]    mem_be_o;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
      .m0_wdata_i(m0_wdata_i), .m0_be_i(m0_be_i), .m0_gnt_o(m0_gnt_o),
      .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
      .m1_wdata_i(m1_wdata_i), .m1_be_i(m1_be_i), .m1_gnt_o(m1_gnt_o),
      .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          due;
      bit          owner;
      logic [31:0] data;
   } resp_t;

   resp_t pend[$];       // outstanding reads, oldest first
   int    cyc    = 0;    // bench cycle number
   int    last   = 1;    // master granted most recently (1 after reset)
   int    errors = 0;
   int    checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic set_m0(input bit req, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      m0_req_i = req; m0_we_i = we; m0_addr_i = a; m0_wdata_i = d; m0_be_i = be;
   endtask

   task automatic set_m1(input bit req, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      m1_req_i = req; m1_we_i = we; m1_addr_i = a; m1_wdata_i = d; m1_be_i = be;
   endtask

   task automatic idle_masters();
      set_m0(0, 0, '0, '0, '0);
      set_m1(0, 0, '0, '0, '0);
   endtask

   // One clock cycle: called at posedge+1, checks at the negedge, returns at next posedge+1
   task automatic run(input bit mg, input bit spur);
      bit          due, e_rv0, e_rv1, r0, r1, w, acc, swe;
      logic [31:0] e_rdata, s_addr, s_wdata;
      logic [3:0]  s_be;
      resp_t       head;
      mem_gnt_i = mg;
      e_rv0 = 0; e_rv1 = 0; e_rdata = '0;
      due = (pend.size() > 0) && (pend[0].due == cyc);
      if (due) begin
         head         = pend.pop_front();
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = head.data;
         e_rdata      = head.data;
         e_rv0        = (head.owner == 1'b0);
         e_rv1        = (head.owner == 1'b1);
      end else begin
         mem_rvalid_i = spur;
         mem_rdata_i  = $urandom;
      end
      r0 = m0_req_i;
      r1 = m1_req_i;
      if (r0 && r1) w = (last == 0);
      else          w = r1;
      acc     = (r0 | r1) & mg;
      swe     = w ? m1_we_i    : m0_we_i;
      s_addr  = w ? m1_addr_i  : m0_addr_i;
      s_wdata = w ? m1_wdata_i : m0_wdata_i;
      s_be    = w ? m1_be_i    : m0_be_i;
      @(negedge clk_i);
      chk("m0_gnt", 32'(m0_gnt_o), 32'(acc & !w));
      chk("m1_gnt", 32'(m1_gnt_o), 32'(acc & w));
      chk("mem_req", 32'(mem_req_o), 32'(r0 | r1));
      if (r0 | r1) begin
         chk("mem_we", 32'(mem_we_o), 32'(swe));
         chk("mem_addr", mem_addr_o, s_addr);
         chk("mem_be", 32'(mem_be_o), swe ? 32'(s_be) : 32'd0);
         if (swe) chk("mem_wdata", mem_wdata_o, s_wdata);
      end
      chk("m0_rvalid", 32'(m0_rvalid_o), 32'(e_rv0));
      chk("m1_rvalid", 32'(m1_rvalid_o), 32'(e_rv1));
      if (e_rv0) chk("m0_rdata", m0_rdata_o, e_rdata);
      if (e_rv1) chk("m1_rdata", m1_rdata_o, e_rdata);
      if (acc) begin
         last = w ? 1 : 0;
         if (!swe) pend.push_back('{due: cyc + LAT, owner: w, data: $urandom});
      end
      @(posedge clk_i); #1;
      cyc++;
   endtask

   // Hold reset for one cycle with every input active; outputs must stay quiet
   task automatic do_reset();
      rst_n_i = 1'b0;
      set_m0(1, 1, 32'h1000, 32'h1111_1111, 4'hF);
      set_m1(1, 1, 32'h2000, 32'h2222_2222, 4'hF);
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
      #2;
      chk("rst_m0_gnt", 32'(m0_gnt_o), 32'd0);
      chk("rst_m1_gnt", 32'(m1_gnt_o), 32'd0);
      chk("rst_m0_rvalid", 32'(m0_rvalid_o), 32'd0);
      chk("rst_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
      chk("rst_mem_req", 32'(mem_req_o), 32'd0);
      chk("rst_mem_we", 32'(mem_we_o), 32'd0);
      chk("rst_mem_be", 32'(mem_be_o), 32'd0);
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      idle_masters();
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      pend.delete();
      last = 1;
      cyc++;
   endtask

   initial begin
      rst_n_i = 1'b0;
      idle_masters();
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      @(posedge clk_i); #1;
      do_reset();

      // Continuous reads from both masters: grants alternate starting with m0
      set_m0(1, 0, 32'h0000_0100, '0, 4'hF);
      set_m1(1, 0, 32'h0000_0200, '0, 4'hF);
      for (int i = 0; i < 6; i++) begin
         m0_addr_i = 32'h100 + 32'(i);
         m1_addr_i = 32'h200 + 32'(i);
         run(1, 0);
      end
      idle_masters();
      for (int i = 0; i < LAT + 1; i++) run(1, 0);

      // Lone write from m0: same-cycle grant, fields passed through, no response
      set_m0(1, 1, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF);
      run(1, 0);
      idle_masters();
      for (int i = 0; i < LAT + 1; i++) run(1, 0);

      // Grant m0, then stall a tie for 3 cycles; m1 must win once accepted
      set_m0(1, 0, 32'h300, '0, 4'h0);
      run(1, 0);
      set_m1(1, 0, 32'h304, '0, 4'h0);
      for (int i = 0; i < 3; i++) run(0, 0);
      run(1, 0);
      idle_masters();
      for (int i = 0; i < LAT + 1; i++) run(1, 0);

      // Back-to-back reads m1, m0, m1 return on cycles +3, +4, +5
      set_m1(1, 0, 32'h500, '0, 4'h0); run(1, 0);
      idle_masters();
      set_m0(1, 0, 32'h504, '0, 4'h0); run(1, 0);
      idle_masters();
      set_m1(1, 0, 32'h508, '0, 4'h0); run(1, 0);
      idle_masters();
      for (int i = 0; i < LAT + 1; i++) run(1, 0);

      // Spurious mem_rvalid_i with nothing in flight
      run(1, 1);
      run(0, 1);

      // Make m0 the last grantee, then a read from m1, reset mid-flight, late response ignored
      set_m0(1, 1, 32'h600, 32'h1234_5678, 4'h3); run(1, 0);
      idle_masters();
      set_m1(1, 0, 32'h604, '0, 4'h0); run(1, 0);
      idle_masters();
      do_reset();
      run(1, 0);
      run(1, 1);
      set_m0(1, 0, 32'h700, '0, 4'h0);
      set_m1(1, 0, 32'h704, '0, 4'h0);
      run(1, 0);
      idle_masters();
      for (int i = 0; i < LAT + 1; i++) run(1, 0);

      // Randomised traffic with random back-pressure and stray rvalids
      for (int i = 0; i < 400; i++) begin
         set_m0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
         set_m1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
         run($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      end
      idle_masters();
      for (int i = 0; i < LAT + 1; i++) run(1, 0);
      chk("drain_empty", 32'(pend.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
